// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the memory port arbiter.
// Holds the arbiter state encoding and the timeout counter sizing helper.
package mem_arb_pkg;

    localparam int unsigned ARB_AW = 32;
    localparam int unsigned ARB_DW = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        FETCH = 2'd2
    } arb_state_e;

    // Counter width able to hold 0..timeout, never narrower than one bit.
    function automatic int unsigned timer_width(input int unsigned timeout);
        return (timeout < 32'd2) ? 32'd1 : $clog2(timeout + 32'd1);
    endfunction

endpackage

// File: rtl/arb_timeout.sv
// Bus wait timer: counts cycles a transaction has been on the bus.
// The count reaches 1 in the first bus cycle, so expire fires in the TIMEOUT-th bus cycle.
module arb_timeout
    import mem_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int unsigned TW = timer_width(TIMEOUT);

    logic [TW-1:0] count_r;
    logic [TW-1:0] base_s;

    assign base_s = clr ? {TW{1'b0}} : count_r;

    // Clear-then-count so a grant in the idle cycle already counts as the first bus cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {TW{1'b0}};
        end else begin
            count_r <= base_s + TW'(en);
        end
    end

    assign expire = (TIMEOUT != 32'd0) && !clr && (count_r == TW'(TIMEOUT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Memory port arbiter: shares one bus port between instruction fetch and the mem stage.
// Data requests win at grant time; an in-flight fetch always finishes on the bus.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW      = ARB_AW,
    parameter int unsigned DW      = ARB_DW,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    input  logic          if_flush,
    output logic          if_ack,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          d_stall,
    output logic          bus_err,
    output logic          bus_cyc,
    output logic          bus_we,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_wdata,
    input  logic          bus_ack,
    input  logic [DW-1:0] bus_rdata
);

    arb_state_e state_r, state_nx;

    logic grant_d_s, grant_f_s, done_s, abort_s, end_s;
    logic busy_s, expire_s, drop_s;

    logic          bus_cyc_r, bus_we_r;
    logic [AW-1:0] bus_addr_r;
    logic [DW-1:0] bus_wdata_r;
    logic          d_ack_r, if_ack_r, bus_err_r, drop_r;
    logic [DW-1:0] d_rdata_r, if_rdata_r;

    assign busy_s = (state_r != IDLE);
    assign end_s  = done_s | abort_s;
    assign drop_s = drop_r | if_flush;

    arb_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clr    (~busy_s),
        .en     (busy_s | grant_d_s | grant_f_s),
        .expire (expire_s)
    );

    // Next-state and grant decode; a requester whose ack is out this cycle is not re-granted.
    always_comb begin
        state_nx  = state_r;
        grant_d_s = 1'b0;
        grant_f_s = 1'b0;
        done_s    = 1'b0;
        abort_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (d_req && !d_ack_r) begin
                    grant_d_s = 1'b1;
                    state_nx  = DATA;
                end else if (if_req && !if_flush && !if_ack_r) begin
                    grant_f_s = 1'b1;
                    state_nx  = FETCH;
                end else begin
                    state_nx  = IDLE;
                end
            end
            DATA, FETCH: begin
                if (bus_ack) begin
                    done_s   = 1'b1;
                    state_nx = IDLE;
                end else if (expire_s) begin
                    abort_s  = 1'b1;
                    state_nx = IDLE;
                end else begin
                    state_nx = state_r;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Bus request registers: latched at grant, held until the cycle after completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_cyc_r   <= 1'b0;
            bus_we_r    <= 1'b0;
            bus_addr_r  <= {AW{1'b0}};
            bus_wdata_r <= {DW{1'b0}};
        end else if (grant_d_s) begin
            bus_cyc_r   <= 1'b1;
            bus_we_r    <= d_we;
            bus_addr_r  <= d_addr;
            bus_wdata_r <= d_wdata;
        end else if (grant_f_s) begin
            bus_cyc_r   <= 1'b1;
            bus_we_r    <= 1'b0;
            bus_addr_r  <= if_addr;
            bus_wdata_r <= {DW{1'b0}};
        end else if (end_s) begin
            bus_cyc_r   <= 1'b0;
            bus_we_r    <= 1'b0;
        end
    end

    // Requester acks and return data; aborted or store transactions return zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_ack_r    <= 1'b0;
            if_ack_r   <= 1'b0;
            bus_err_r  <= 1'b0;
            d_rdata_r  <= {DW{1'b0}};
            if_rdata_r <= {DW{1'b0}};
        end else begin
            d_ack_r   <= (state_r == DATA) && end_s;
            if_ack_r  <= (state_r == FETCH) && end_s && !drop_s;
            bus_err_r <= abort_s;
            if ((state_r == DATA) && end_s) begin
                d_rdata_r <= (abort_s || bus_we_r) ? {DW{1'b0}} : bus_rdata;
            end
            if ((state_r == FETCH) && end_s && !drop_s) begin
                if_rdata_r <= abort_s ? {DW{1'b0}} : bus_rdata;
            end
        end
    end

    // Flushed-fetch flag: set by a redirect while the fetch is on the bus, cleared once idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_r <= 1'b0;
        end else if (state_r == IDLE) begin
            drop_r <= 1'b0;
        end else if ((state_r == FETCH) && if_flush) begin
            drop_r <= 1'b1;
        end
    end

    assign bus_cyc   = bus_cyc_r;
    assign bus_we    = bus_we_r;
    assign bus_addr  = bus_addr_r;
    assign bus_wdata = bus_wdata_r;
    assign d_ack     = d_ack_r;
    assign d_rdata   = d_rdata_r;
    assign if_ack    = if_ack_r;
    assign if_rdata  = if_rdata_r;
    assign bus_err   = bus_err_r;
    assign d_stall   = d_req & ~d_ack_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by randomized requesters and a
// random-latency bus, all checked every cycle against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0, if_flush = 1'b0, d_req = 1'b0, d_we = 1'b0, bus_ack = 1'b0;
    logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0, bus_rdata = '0;
    logic        if_ack, d_ack, d_stall, bus_err, bus_cyc, bus_we;
    logic [31:0] if_rdata, d_rdata, bus_addr, bus_wdata;

    int total = 0;
    int bad   = 0;

    mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_stall(d_stall), .bus_err(bus_err),
        .bus_cyc(bus_cyc), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    // Reference model: who owns the bus, how long it has waited, and what each output should be.
    typedef enum int {OWN_NONE, OWN_DATA, OWN_FETCH} own_e;
    own_e        m_own  = OWN_NONE;
    int          m_busy = 0;
    bit          m_drop = 1'b0;
    logic        e_cyc = 1'b0, e_we = 1'b0, e_dack = 1'b0, e_iack = 1'b0, e_err = 1'b0, e_zero = 1'b1;
    logic [31:0] e_addr = '0, e_wdata = '0, e_drdata = '0, e_irdata = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        logic n_dack, n_iack, n_err, timed_out;
        n_dack = 1'b0;
        n_iack = 1'b0;
        n_err  = 1'b0;
        e_zero = rst;
        if (rst) begin
            m_own = OWN_NONE; m_busy = 0; m_drop = 1'b0;
            e_cyc = 1'b0; e_we = 1'b0; e_addr = '0; e_wdata = '0; e_drdata = '0; e_irdata = '0;
        end else if (m_own == OWN_NONE) begin
            m_drop = 1'b0;
            if (d_req && !e_dack) begin
                m_own = OWN_DATA; m_busy = 1;
                e_cyc = 1'b1; e_we = d_we; e_addr = d_addr; e_wdata = d_wdata;
            end else if (if_req && !if_flush && !e_iack) begin
                m_own = OWN_FETCH; m_busy = 1;
                e_cyc = 1'b1; e_we = 1'b0; e_addr = if_addr; e_wdata = '0;
            end
        end else begin
            if (m_own == OWN_FETCH && if_flush) m_drop = 1'b1;
            timed_out = !bus_ack && (TMO != 0) && (m_busy == TMO);
            if (bus_ack || timed_out) begin
                if (m_own == OWN_DATA) begin
                    n_dack = 1'b1;
                    e_drdata = (timed_out || e_we) ? 32'h0 : bus_rdata;
                end else if (!m_drop) begin
                    n_iack = 1'b1;
                    e_irdata = timed_out ? 32'h0 : bus_rdata;
                end
                n_err = timed_out;
                e_cyc = 1'b0;
                m_own = OWN_NONE;
            end else begin
                m_busy++;
            end
        end
        e_dack = n_dack;
        e_iack = n_iack;
        e_err  = n_err;
    endtask

    task automatic check_outputs();
        check("bus_cyc", 32'(bus_cyc), 32'(e_cyc));
        check("d_ack", 32'(d_ack), 32'(e_dack));
        check("if_ack", 32'(if_ack), 32'(e_iack));
        check("bus_err", 32'(bus_err), 32'(e_err));
        if (e_cyc || e_zero) begin
            check("bus_we", 32'(bus_we), 32'(e_we));
            check("bus_addr", bus_addr, e_addr);
            check("bus_wdata", bus_wdata, e_wdata);
        end
        if (e_dack || e_zero) check("d_rdata", d_rdata, e_drdata);
        if (e_iack || e_zero) check("if_rdata", if_rdata, e_irdata);
    endtask

    // One clock: inputs are already applied at a falling edge; check again at the next one.
    task automatic tick();
        #1;
        check("d_stall", 32'(d_stall), 32'(d_req & ~e_dack));
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic drv(input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd,
                       input logic ir, input logic [31:0] ia, input logic fl,
                       input logic ba, input logic [31:0] br);
        d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
        if_req = ir; if_addr = ia; if_flush = fl;
        bus_ack = ba; bus_rdata = br;
        tick();
    endtask

    bit d_done = 1'b0, i_done = 1'b0;
    int rsp_cnt = -1;

    initial begin
        // reset state
        rst = 1'b1;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        drv(1, 0, 32'h10, 0, 0, 0, 0, 0, 0);
        check("rst_stall", 32'(d_stall), 32'd1);
        rst = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // 1: idle fetch
        drv(0, 0, 0, 0, 1, 32'h100, 0, 0, 0);
        check("t1_cyc", 32'(bus_cyc), 32'd1);
        check("t1_addr", bus_addr, 32'h100);
        drv(0, 0, 0, 0, 1, 32'h100, 0, 0, 0);
        drv(0, 0, 0, 0, 1, 32'h100, 0, 1, 32'h00500093);
        check("t1_if_ack", 32'(if_ack), 32'd1);
        check("t1_if_rdata", if_rdata, 32'h00500093);
        drv(0, 0, 0, 0, 1, 32'h100, 0, 0, 0);
        check("t1_no_regrant", 32'(bus_cyc), 32'd0);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // 2: contention, data first then fetch after one idle cycle
        drv(1, 0, 32'h2000, 0, 1, 32'h104, 0, 0, 0);
        check("t2_data_first", bus_addr, 32'h2000);
        drv(1, 0, 32'h2000, 0, 1, 32'h104, 0, 1, 32'h12345678);
        check("t2_d_ack", 32'(d_ack), 32'd1);
        check("t2_d_rdata", d_rdata, 32'h12345678);
        check("t2_gap", 32'(bus_cyc), 32'd0);
        drv(1, 0, 32'h2000, 0, 1, 32'h104, 0, 0, 0);
        check("t2_fetch_addr", bus_addr, 32'h104);
        drv(0, 0, 0, 0, 1, 32'h104, 0, 1, 32'h00000013);
        check("t2_if_rdata", if_rdata, 32'h00000013);
        drv(0, 0, 0, 0, 1, 32'h104, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // 3: flush while fetch is in flight
        drv(0, 0, 0, 0, 1, 32'h200, 0, 0, 0);
        drv(0, 0, 0, 0, 1, 32'h300, 1, 0, 0);
        drv(0, 0, 0, 0, 1, 32'h300, 0, 0, 0);
        check("t3_addr_hold", bus_addr, 32'h200);
        drv(0, 0, 0, 0, 1, 32'h300, 0, 0, 0);
        drv(0, 0, 0, 0, 1, 32'h300, 0, 1, 32'hBAD00BAD);
        check("t3_no_if_ack", 32'(if_ack), 32'd0);
        drv(0, 0, 0, 0, 1, 32'h300, 0, 0, 0);
        check("t3_new_pc", bus_addr, 32'h300);
        drv(0, 0, 0, 0, 1, 32'h300, 0, 1, 32'h00000033);
        check("t3_if_rdata", if_rdata, 32'h00000033);
        drv(0, 0, 0, 0, 1, 32'h300, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // 4: store
        drv(1, 1, 32'h3000, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        check("t4_we", 32'(bus_we), 32'd1);
        check("t4_wdata", bus_wdata, 32'hDEADBEEF);
        drv(1, 1, 32'h3000, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        drv(1, 1, 32'h3000, 32'hDEADBEEF, 0, 0, 0, 1, 32'hFFFFFFFF);
        check("t4_d_rdata", d_rdata, 32'h0);
        drv(1, 1, 32'h3000, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // 5: timeout abort
        for (int i = 0; i < 4; i++) drv(1, 0, 32'h4000, 0, 0, 0, 0, 0, 0);
        check("t5_cyc_last", 32'(bus_cyc), 32'd1);
        drv(1, 0, 32'h4000, 0, 0, 0, 0, 0, 0);
        check("t5_cyc_drop", 32'(bus_cyc), 32'd0);
        check("t5_err", 32'(bus_err), 32'd1);
        check("t5_d_ack", 32'(d_ack), 32'd1);
        drv(1, 0, 32'h4000, 0, 0, 0, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // 6: reset in the middle of a data transaction
        drv(1, 0, 32'h5000, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("t6_cyc", 32'(bus_cyc), 32'd0);
        rst = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 0, 1, 32'h5555AAAA);
        check("t6_no_ack", 32'(d_ack), 32'd0);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // randomized requesters, bus latency and occasional reset
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(299) == 0);
            if (rst) begin
                d_req = 1'b0; if_req = 1'b0; d_done = 1'b0; i_done = 1'b0;
            end
            if (d_done) begin
                d_req = 1'b0; d_done = 1'b0;
            end else if (d_req) begin
                if (d_ack) d_done = 1'b1;
            end else if (!rst && $urandom_range(3) == 0) begin
                d_req = 1'b1; d_we = 1'($urandom_range(1));
                d_addr = $urandom; d_wdata = $urandom;
            end
            if_flush = 1'b0;
            if (i_done) begin
                if_req = 1'b0; i_done = 1'b0;
            end else if (if_req) begin
                if (if_ack) i_done = 1'b1;
                else if ($urandom_range(11) == 0) begin
                    if_flush = 1'b1; if_addr = $urandom & 32'hFFFFFFFC;
                end
            end else if (!rst && $urandom_range(2) == 0) begin
                if_req = 1'b1; if_addr = $urandom & 32'hFFFFFFFC;
            end
            bus_ack = 1'b0;
            if (!bus_cyc) begin
                rsp_cnt = -1;
            end else begin
                if (rsp_cnt < 0) rsp_cnt = $urandom_range(5);
                if (rsp_cnt == 0) begin
                    bus_ack = 1'b1; bus_rdata = $urandom; rsp_cnt = 99;
                end else begin
                    rsp_cnt--;
                end
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
